data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Memory-side responder for the pipelined core's data port: accepts one load/store request at a time over a
//  req/ready handshake, inserts programmable wait states, and returns read data with a one-cycle ready pulse.
//  Sits between the EX/MEM stage and word-addressed on-chip data RAM. Lets the core be verified against variable latency.
// PARAMETERS
//  DATA_WIDTH   32    data word width (bits)
//  MEMORY_DEPTH 256   number of words; ADDR_BITS = $clog2(MEMORY_DEPTH)
//  WAIT_STATES  2     extra cycles between request accept and response (0..15)
//  MMIO_ADDR    32'h0000_0FFC  byte address of GPIO register (used only with DMEM_MMIO_EN)
// PORTS
//  clk              in   1   clock; all state changes on rising edge
//  reset            in   1   asynchronous, active-low reset
//  in_Req           in   1   request valid; initiator holds it, with stable fields, until o_Ready
//  in_MemRead       in   1   load request
//  in_MemWrite      in   1   store request
//  in_Address_dw    in   32  byte address
//  in_WriteData_dw  in   32  store data
//  o_ReadData_dw    out  32  load data; valid only while o_Ready=1
//  o_Ready          out  1   one-cycle response pulse; completes the transaction
//  o_Busy           out  1   1 from accept until the cycle after o_Ready
//  o_AddrError      out  1   qualifies o_Ready: request rejected, no side effect
//  o_Gpio_dw        out  32  GPIO register (present only with DMEM_MMIO_EN)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, wait counter 0, o_ReadData_dw=0, o_Ready=0, o_Busy=0, o_AddrError=0,
//   o_Gpio_dw=0. RAM contents are not cleared. Reset mid-transaction drops it; a pending store is never written.
//  FSM: IDLE -> (accept) -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_STATES=0.
//   IDLE: accept when in_Req=1; latch address, data, read/write kind; o_Busy=1 next cycle.
//   WAIT: counter counts 0..WAIT_STATES-1; leave at terminal count. Input changes ignored.
//   RESP: o_Ready=1 for exactly one cycle; then IDLE unconditionally.
//  Latency: o_Ready rises WAIT_STATES+1 cycles after accept edge. A request held through RESP is a NEW request:
//   one mandatory IDLE bubble between back-to-back transactions (throughput 1 per WAIT_STATES+2 cycles).
//  Store commits on the edge entering RESP; a load issued after store response sees the new data.
//  Load data registered on the edge entering RESP; o_ReadData_dw returns to 0 when o_Ready drops.
//  Word index = address[ADDR_BITS+1:2]. Error (o_AddrError=1 with o_Ready, no write, data 0) when:
//   address[1:0]!=0; address >= 4*MEMORY_DEPTH (except MMIO_ADDR if enabled); MemRead and MemWrite both 1;
//   in_Req=1 with neither set. Error responses take the same latency as good ones.
//  o_AddrError and o_ReadData_dw are 0 whenever o_Ready=0.
// CONFIGURATION
//  DMEM_MMIO_EN defined: port o_Gpio_dw exists; MMIO_ADDR decodes to the GPIO register (bypasses range check);
//   store updates it on edge entering RESP, load returns its value. MMIO_ADDR inside RAM range: MMIO wins.
//  DMEM_MMIO_EN undefined: no o_Gpio_dw port, no register; MMIO_ADDR is an ordinary address (range-checked).
// STRUCTURE
//  Package dmem_pkg: state enum {IDLE, WAIT, RESP}, error-condition helper function, default WAIT_STATES/depth constants.
//  Sub-module dmem_storage_ram: single-port synchronous RAM (write enable, word address, registered read), no reset.
//  Top holds FSM, wait counter, request latch, address decode, MMIO register.
// TESTING
//  Reset: hold reset=0 3 cycles with in_Req=1 -> all outputs 0, no o_Ready; release -> request accepted next edge.
//  Store 32'hDEAD_BEEF @0x10, then load @0x10 (WAIT_STATES=2) -> o_Ready 3 cycles after each accept, read=DEAD_BEEF.
//  Load @0x12 and @0x400 (depth 256) -> o_Ready with o_AddrError=1, data 0; RAM word 4 unchanged.
//  Back-to-back: in_Req held high for two loads -> exactly one idle cycle between o_Ready pulses, o_Busy=0 there.
//  Reset asserted during WAIT of store 32'h1234 @0x20 -> word 8 retains prior value, FSM IDLE, o_Busy=0.
//  DMEM_MMIO_EN: store 32'h0000_00A5 @MMIO_ADDR -> o_Gpio_dw=A5 on response edge; load returns A5; undefined -> error.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
// FSM state encoding, defaults and the request-error decode.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState_e;

    localparam int DEFAULT_WAIT_STATES  = 2;
    localparam int DEFAULT_MEMORY_DEPTH = 256;

    // An MMIO hit bypasses the range check but not alignment or kind checks.
    function automatic logic reqError(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input logic [32:0] byteLimit,
        input logic        mmioHit
    );
        logic misaligned;
        logic outOfRange;
        logic badKind;
        misaligned = (addr[1:0] != 2'b00);
        outOfRange = !mmioHit && ({1'b0, addr} >= byteLimit);
        badKind    = (rd == wr);
        return misaligned | outOfRange | badKind;
    endfunction

endpackage

// File: rtl/dmem_storage_ram.sv
// dmem_storage_ram: single-port word RAM, synchronous write and
// registered read, contents never reset.
module dmem_storage_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  writeEn,
    input  logic                  readEn,
    input  logic [ADDR_BITS-1:0]  wordAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[wordAddr] <= writeData;
        end
        if (readEn) begin
            readData <= mem[wordAddr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: req/ready data-port responder with programmable
// wait states; define DMEM_MMIO_EN to add a GPIO register at MMIO_ADDR.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
    parameter int          WAIT_STATES  = DEFAULT_WAIT_STATES,
    parameter logic [31:0] MMIO_ADDR    = 32'h0000_0FFC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Req,
    input  logic                  in_MemRead,
    input  logic                  in_MemWrite,
    input  logic [31:0]           in_Address_dw,
    input  logic [DATA_WIDTH-1:0] in_WriteData_dw,
    output logic [DATA_WIDTH-1:0] o_ReadData_dw,
    output logic                  o_Ready,
    output logic                  o_Busy,
    output logic                  o_AddrError
`ifdef DMEM_MMIO_EN
    ,
    output logic [DATA_WIDTH-1:0] o_Gpio_dw
`endif
);

    localparam int ADDR_BITS = $clog2(MEMORY_DEPTH);
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * MEMORY_DEPTH);
    localparam logic [3:0] WAIT_LAST =
        4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
`ifdef DMEM_MMIO_EN
    localparam logic MMIO_EN = 1'b1;
`else
    localparam logic MMIO_EN = 1'b0;
`endif

    dmemState_e            state;
    dmemState_e            stateNext;
    logic [3:0]            waitCnt;
    logic [3:0]            waitCntNext;
    logic [ADDR_BITS-1:0]  reqIdx;
    logic [ADDR_BITS-1:0]  effIdx;
    logic [DATA_WIDTH-1:0] reqData;
    logic [DATA_WIDTH-1:0] effData;
    logic [DATA_WIDTH-1:0] ramRdata;
    logic [DATA_WIDTH-1:0] mmioRdata;
    logic                  reqRead;
    logic                  reqWrite;
    logic                  reqErr;
    logic                  reqMmio;
    logic                  effRead;
    logic                  effWrite;
    logic                  effErr;
    logic                  effMmio;
    logic                  inMmio;
    logic                  inErr;
    logic                  accept;
    logic                  enterResp;
    logic                  doWrite;
    logic                  doRead;

    assign inMmio = MMIO_EN && (in_Address_dw == MMIO_ADDR);
    assign inErr  = reqError(in_Address_dw, in_MemRead,
                             in_MemWrite, BYTE_LIMIT, inMmio);

    // With zero wait states RESP is entered on the accept edge itself,
    // so the commit path must see the live request, not the latch.
    assign effIdx   = accept ? in_Address_dw[ADDR_BITS+1:2] : reqIdx;
    assign effData  = accept ? in_WriteData_dw : reqData;
    assign effRead  = accept ? in_MemRead : reqRead;
    assign effWrite = accept ? in_MemWrite : reqWrite;
    assign effErr   = accept ? inErr : reqErr;
    assign effMmio  = accept ? inMmio : reqMmio;

    assign doWrite = enterResp && effWrite && !effErr && !effMmio;
    assign doRead  = enterResp && effRead && !effErr && !effMmio;

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        enterResp   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_Req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        stateNext = RESP;
                        enterResp = 1'b1;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == WAIT_LAST) begin
                    stateNext   = RESP;
                    waitCntNext = '0;
                    enterResp   = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 4'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext   = IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            reqIdx   <= '0;
            reqData  <= '0;
            reqRead  <= 1'b0;
            reqWrite <= 1'b0;
            reqErr   <= 1'b0;
            reqMmio  <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (accept) begin
                reqIdx   <= in_Address_dw[ADDR_BITS+1:2];
                reqData  <= in_WriteData_dw;
                reqRead  <= in_MemRead;
                reqWrite <= in_MemWrite;
                reqErr   <= inErr;
                reqMmio  <= inMmio;
            end
        end
    end

    dmem_storage_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH),
        .ADDR_BITS  (ADDR_BITS)
    ) uRam (
        .clk       (clk),
        .writeEn   (doWrite),
        .readEn    (doRead),
        .wordAddr  (effIdx),
        .writeData (effData),
        .readData  (ramRdata)
    );

`ifdef DMEM_MMIO_EN
    logic [DATA_WIDTH-1:0] gpioReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpioReg <= '0;
        end else if (enterResp && effWrite && effMmio && !effErr) begin
            gpioReg <= effData;
        end
    end

    assign o_Gpio_dw = gpioReg;
    assign mmioRdata = gpioReg;
`else
    assign mmioRdata = '0;
`endif

    assign o_Ready       = (state == RESP);
    assign o_Busy        = (state != IDLE);
    assign o_AddrError   = o_Ready && reqErr;
    assign o_ReadData_dw = (o_Ready && reqRead && !reqErr)
                         ? (reqMmio ? mmioRdata : ramRdata)
                         : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for the data-memory responder.
// Expected responses are queued at issue and checked on each o_Ready pulse.
module tb_data_memory_responder;

    localparam int WS = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_Req = 1'b0;
    logic        in_MemRead = 1'b0;
    logic        in_MemWrite = 1'b0;
    logic [31:0] in_Address_dw = '0;
    logic [31:0] in_WriteData_dw = '0;
    logic [31:0] o_ReadData_dw;
    logic        o_Ready;
    logic        o_Busy;
    logic        o_AddrError;
`ifdef DMEM_MMIO_EN
    logic [31:0] o_Gpio_dw;
`endif

    int   tests = 0;
    int   failures = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    data_memory_responder #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (256),
        .WAIT_STATES  (WS),
        .MMIO_ADDR    (32'h0000_0FFC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_Req          (in_Req),
        .in_MemRead      (in_MemRead),
        .in_MemWrite     (in_MemWrite),
        .in_Address_dw   (in_Address_dw),
        .in_WriteData_dw (in_WriteData_dw),
        .o_ReadData_dw   (o_ReadData_dw),
        .o_Ready         (o_Ready),
        .o_Busy          (o_Busy),
        .o_AddrError     (o_AddrError)
`ifdef DMEM_MMIO_EN
        ,
        .o_Gpio_dw       (o_Gpio_dw)
`endif
    );

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        in_Req          = 1'b1;
        in_MemRead      = rd;
        in_MemWrite     = wr;
        in_Address_dw   = addr;
        in_WriteData_dw = wdata;
    endtask

    task automatic idle_inputs();
        in_Req      = 1'b0;
        in_MemRead  = 1'b0;
        in_MemWrite = 1'b0;
    endtask

    // Called just after a rising edge with the request already driven.
    task automatic wait_resp(input string name);
        int   cyc = 0;
        bit   seen = 0;
        bit   busyOk = 1;
        bit   quietOk = 1;
        exp_t e;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (o_Busy !== (cyc != 0)) busyOk = 0;
            if (o_Ready === 1'b1) begin
                seen = 1;
                tests++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL %s_resp: unexpected response data=%h err=%b",
                             name, o_ReadData_dw, o_AddrError);
                end else begin
                    e = expQ.pop_front();
                    if (o_ReadData_dw !== e.data || o_AddrError !== e.err) begin
                        failures++;
                        $display("FAIL %s_resp: got data=%h err=%b required data=%h err=%b",
                                 name, o_ReadData_dw, o_AddrError, e.data, e.err);
                    end
                end
            end else begin
                if (o_ReadData_dw !== '0 || o_AddrError !== 1'b0) quietOk = 0;
                cyc++;
            end
        end
        tests++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: no o_Ready within %0d cycles, required %0d",
                     name, cyc, WS + 1);
        end else if (cyc != WS + 1) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles required %0d",
                     name, cyc, WS + 1);
        end
        tests++;
        if (!busyOk) begin
            failures++;
            $display("FAIL %s_busy: o_Busy wrong during transaction, required 0 then 1",
                     name);
        end
        tests++;
        if (!quietOk) begin
            failures++;
            $display("FAIL %s_quiet: data/err nonzero while o_Ready=0, required 0",
                     name);
        end
    endtask

    task automatic run_req(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expData, input logic expErr,
                           input string name);
        drive(rd, wr, addr, wdata);
        expQ.push_back('{expData, expErr});
        wait_resp(name);
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 32'h0000_0012, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (o_Ready !== 1'b0 || o_Busy !== 1'b0 || o_AddrError !== 1'b0 ||
                o_ReadData_dw !== '0) begin
                failures++;
                $display("FAIL reset_outputs: rdy=%b busy=%b err=%b data=%h required all 0",
                         o_Ready, o_Busy, o_AddrError, o_ReadData_dw);
            end
        end
`ifdef DMEM_MMIO_EN
        tests++;
        if (o_Gpio_dw !== '0) begin
            failures++;
            $display("FAIL reset_gpio: got %h required 0", o_Gpio_dw);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.push_back('{32'h0, 1'b1});
        wait_resp("reset_release");
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        run_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "store_10");
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "load_10");
        run_req(1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0, "store_last");
        run_req(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 32'h0, 1'b0, "store_0");
        run_req(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'hCAFE_F00D, 1'b0, "load_last");
        run_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_C0DE, 1'b0, "load_0");
    endtask

    task automatic test_addr_error();
        run_req(1'b1, 1'b0, 32'h0000_0012, 32'h0, 32'h0, 1'b1, "load_misaligned");
        run_req(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1, "load_range");
        run_req(1'b0, 1'b1, 32'h0000_0012, 32'h1111_1111, 32'h0, 1'b1, "store_misaligned");
        run_req(1'b0, 1'b1, 32'h0000_0410, 32'h2222_2222, 32'h0, 1'b1, "store_range");
        run_req(1'b1, 1'b1, 32'h0000_0010, 32'h3333_3333, 32'h0, 1'b1, "both_kinds");
        run_req(1'b0, 1'b0, 32'h0000_0010, 32'h4444_4444, 32'h0, 1'b1, "no_kind");
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "word4_kept");
        run_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_C0DE, 1'b0, "word0_kept");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        expQ.push_back('{32'hDEAD_BEEF, 1'b0});
        wait_resp("b2b_first");
        in_Address_dw = 32'h0000_03FC;
        expQ.push_back('{32'hCAFE_F00D, 1'b0});
        wait_resp("b2b_second");
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_store();
        run_req(1'b0, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0, 1'b0, "store_20");
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234);
        @(posedge clk);
        #1;
        tests++;
        if (o_Busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_accept: o_Busy=%b required 1", o_Busy);
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        tests++;
        if (o_Busy !== 1'b0 || o_Ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle: busy=%b rdy=%b required 0 0", o_Busy, o_Ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 1'b0, "midrst_word8");
    endtask

    task automatic test_mmio();
`ifdef DMEM_MMIO_EN
        run_req(1'b0, 1'b1, 32'h0000_0FFC, 32'h0000_00A5, 32'h0, 1'b0, "mmio_store");
        tests++;
        if (o_Gpio_dw !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL mmio_gpio: got %h required 000000a5", o_Gpio_dw);
        end
        run_req(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0000_00A5, 1'b0, "mmio_load");
`else
        run_req(1'b0, 1'b1, 32'h0000_0FFC, 32'h0000_00A5, 32'h0, 1'b1, "mmio_store");
        run_req(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0, 1'b1, "mmio_load");
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_addr_error();
        test_back_to_back();
        test_reset_mid_store();
        test_mmio();
        repeat (3) @(posedge clk);
        tests++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0",
                     expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
